// File: rtl/result_stream_encoder.sv
// Reads the solution vector X back from RAM and streams it to the CPU as
// 8-bit run-length codes {1'b0, bit, run[5:0]}, one word at a time, MSB first.
module result_stream_encoder #(
  parameter int N    = 32,
  parameter int AW   = 20,
  parameter int BASE = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [15:0]   count,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [N-1:0]  mem_data,
  output logic [7:0]    code,
  output logic          code_valid,
  input  logic          code_ready,
  output logic          eob,
  output logic          busy,
  output logic          done,
  output logic [2:0]    dbg_state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] SCAN  = 3'd3;
  localparam logic [2:0] EMIT  = 3'd4;
  localparam logic [2:0] FIN   = 3'd5;

  logic [2:0]   state;
  logic [15:0]  words_left;
  logic [N-1:0] sh;
  logic [5:0]   rem;
  logic [5:0]   run;
  logic         cur;

  // Handshake: a code transfers on a rising edge where code_valid and
  // code_ready are both high; code_valid never drops and code/eob never
  // change until that transfer happens.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      words_left <= '0;
      mem_addr   <= '0;
      sh         <= '0;
      rem        <= '0;
      run        <= '0;
      cur        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            words_left <= count;
            mem_addr   <= AW'(BASE);
            state      <= FETCH;
          end
        end
        // A zero-length stream passes through FETCH without reading RAM.
        FETCH: state <= (words_left == 16'd0) ? FIN : WAIT;
        WAIT: begin
          sh    <= mem_data;
          rem   <= 6'(N);
          run   <= '0;
          state <= SCAN;
        end
        SCAN: begin
          if (run == 6'd0 || sh[N-1] == cur) begin
            cur <= sh[N-1];
            run <= run + 6'd1;
            sh  <= sh << 1;
            rem <= rem - 6'd1;
            // Leave as soon as the word is exhausted or the next bit breaks the run.
            if (rem == 6'd1 || sh[N-2] != sh[N-1]) state <= EMIT;
          end else begin
            state <= EMIT;
          end
        end
        EMIT: begin
          if (code_ready) begin
            if (rem != 6'd0) begin
              run   <= '0;
              state <= SCAN;
            end else if (words_left > 16'd1) begin
              words_left <= words_left - 16'd1;
              mem_addr   <= mem_addr + AW'(1);
              state      <= FETCH;
            end else begin
              state <= FIN;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_rd     = (state == FETCH) && (words_left != 16'd0);
  assign code_valid = (state == EMIT);
  assign code       = code_valid ? {1'b0, cur, run} : 8'h00;
  assign eob        = code_valid && (rem == 6'd0) && (words_left == 16'd1);
  assign busy       = (state != IDLE);
  assign done       = (state == FIN);
  assign dbg_state  = state;

endmodule

// File: tb/tb_result_stream_encoder.sv
// Directed bench for result_stream_encoder: RAM model, code scoreboard with
// backpressure hold checks, and timing checks on done/busy.
module tb_result_stream_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] count = '0;
  logic        mem_rd;
  logic [19:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic [7:0]  code;
  logic        code_valid;
  logic        code_ready = 1'b1;
  logic        eob;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int valid_cnt = 0;
  int t0;
  int v0;

  logic [31:0] ram [0:63];
  logic [8:0]  exp_q [$];
  logic [19:0] addr_q [$];

  bit   bp = 0;
  int   stall = 0;
  bit   prev_stall = 0;
  logic [7:0] prev_code = '0;
  logic       prev_eob = 1'b0;

  result_stream_encoder #(.N(32), .AW(20), .BASE(20)) dut (
    .clk(clk), .reset(reset), .start(start), .count(count),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .code(code), .code_valid(code_valid), .code_ready(code_ready),
    .eob(eob), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // RAM: data valid exactly one cycle after the read strobe
  always @(posedge clk) if (mem_rd) mem_data <= ram[mem_addr[5:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_code(input logic [7:0] c, input logic e);
    exp_q.push_back({e, c});
  endtask

  task automatic do_start(input logic [15:0] c, output int ts);
    @(posedge clk); #1;
    start = 1'b1;
    count = c;
    ts = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int ts, input int exp_lat, input string tag);
    bit seen;
    seen = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen && exp_lat >= 0) check({tag, "_done_latency"}, 32'(cyc - ts), 32'(exp_lat));
    @(negedge clk);
    check({tag, "_busy_low_after_done"}, 32'(busy), 32'd0);
    check({tag, "_codes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Ready driver: in backpressure mode each code is stalled 5 cycles
  always @(posedge clk) begin
    #1;
    if (!bp) begin
      code_ready = 1'b1;
      stall = 0;
    end else if (code_valid) begin
      if (stall < 5) begin
        code_ready = 1'b0;
        stall++;
      end else begin
        code_ready = 1'b1;
        stall = 0;
      end
    end else begin
      code_ready = 1'b0;
      stall = 0;
    end
  end

  // Scoreboard / monitor
  always @(negedge clk) begin
    if (reset) begin
      if (mem_rd) addr_q.push_back(mem_addr);
      if (code_valid) valid_cnt++;
      if (prev_stall) begin
        check("hold_valid", 32'(code_valid), 32'd1);
        check("hold_code", 32'(code), 32'(prev_code));
        check("hold_eob", 32'(eob), 32'(prev_eob));
      end
      if (code_valid && code_ready) begin
        check("code_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("code", 32'(code), 32'(e[7:0]));
          check("eob", 32'(eob), 32'(e[8]));
        end
      end
      prev_stall = code_valid && !code_ready;
      prev_code  = code;
      prev_eob   = eob;
    end else begin
      prev_stall = 0;
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_code_valid", 32'(code_valid), 32'd0);
    check("rst_eob", 32'(eob), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_code", 32'(code), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Single all-zero word
    ram[20] = 32'h0000_0000;
    exp_code(8'h20, 1'b1);
    addr_q.delete();
    do_start(16'd1, t0);
    wait_done(t0, 36, "zero_word");
    check("zero_word_nreads", 32'(addr_q.size()), 32'd1);
    if (addr_q.size() > 0) check("zero_word_addr", 32'(addr_q[0]), 32'd20);

    // Single all-ones word
    ram[20] = 32'hFFFF_FFFF;
    exp_code(8'h60, 1'b1);
    do_start(16'd1, t0);
    wait_done(t0, 36, "ones_word");

    // 0x80000001: three runs
    ram[20] = 32'h8000_0001;
    exp_code(8'h41, 1'b0);
    exp_code(8'h1E, 1'b0);
    exp_code(8'h41, 1'b1);
    do_start(16'd1, t0);
    wait_done(t0, 38, "ends_word");

    // Three words, 1 + 2 + 32 codes
    ram[20] = 32'h0000_0000;
    ram[21] = 32'hFFFF_0000;
    ram[22] = 32'hAAAA_AAAA;
    exp_code(8'h20, 1'b0);
    exp_code(8'h50, 1'b0);
    exp_code(8'h10, 1'b0);
    for (int i = 0; i < 16; i++) begin
      exp_code(8'h41, 1'b0);
      exp_code(8'h01, i == 15);
    end
    addr_q.delete();
    do_start(16'd3, t0);
    wait_done(t0, 138, "three_words");
    check("three_words_nreads", 32'(addr_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < addr_q.size()) check("three_words_addr", 32'(addr_q[i]), 32'(20 + i));

    // Backpressure with a stray start mid-stream
    ram[20] = 32'h8000_0001;
    ram[21] = 32'hF0F0_F0F0;
    exp_code(8'h41, 1'b0);
    exp_code(8'h1E, 1'b0);
    exp_code(8'h41, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_code(8'h44, 1'b0);
      exp_code(8'h04, i == 3);
    end
    addr_q.delete();
    bp = 1;
    do_start(16'd2, t0);
    repeat (40) @(posedge clk);
    #1;
    check("bp_busy_mid", 32'(busy), 32'd1);
    start = 1'b1;
    count = 16'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(t0, -1, "backpressure");
    bp = 0;
    check("bp_nreads", 32'(addr_q.size()), 32'd2);
    for (int i = 0; i < 2; i++)
      if (i < addr_q.size()) check("bp_addr", 32'(addr_q[i]), 32'(20 + i));

    // Zero-length stream
    addr_q.delete();
    v0 = valid_cnt;
    do_start(16'd0, t0);
    wait_done(t0, 2, "zero_len");
    check("zero_len_nreads", 32'(addr_q.size()), 32'd0);
    check("zero_len_valids", 32'(valid_cnt - v0), 32'd0);

    // Reset low during SCAN, then restart
    ram[20] = 32'h0000_0000;
    do_start(16'd1, t0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_state_scan", 32'(dbg_state), 32'd3);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_mem_rd", 32'(mem_rd), 32'd0);
    check("mid_rst_code_valid", 32'(code_valid), 32'd0);
    check("mid_rst_eob", 32'(eob), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_code", 32'(code), 32'd0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    addr_q.delete();
    ram[20] = 32'hFFFF_FFFF;
    exp_code(8'h60, 1'b1);
    do_start(16'd1, t0);
    wait_done(t0, 36, "restart");
    check("restart_nreads", 32'(addr_q.size()), 32'd1);
    if (addr_q.size() > 0) check("restart_addr", 32'(addr_q[0]), 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
